// File: rtl/pixel_frame_scheduler.sv
// Frame-level sequencer for the pixel uploader DMA: restarts it on each frame boundary,
// double-buffers between two frame buffers and tracks uploader read errors.
module pixel_frame_scheduler #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_run,
  input  logic [31:0] cfg_buf0_addr,
  input  logic [31:0] cfg_buf1_addr,
  input  logic [31:0] cfg_frame_size,
  input  logic        cfg_word_mode,
  input  logic        cfg_transform,
  input  logic        frame_start,
  input  logic        host_swap_req,
  input  logic        up_read_error,
  output logic        up_enable,
  output logic [31:0] up_base_address,
  output logic [31:0] up_total_size,
  output logic        up_word_mode,
  output logic        up_transform,
  output logic        fifo_flush,
  output logic        front_buf,
  output logic        swap_done,
  output logic        err_irq,
  output logic [7:0]  err_count,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RESTART = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] gap_cnt;
  logic       swap_pending;
  logic       restart_entry;
  logic       new_front;

  // A read error in RUN takes precedence over a simultaneous frame boundary.
  always_comb begin
    restart_entry = 1'b0;
    if (cfg_run && frame_start) begin
      case (state)
        ST_RUN:  restart_entry = !up_read_error;
        default: restart_entry = 1'b1;
      endcase
    end
  end

  assign new_front = swap_pending ? ~front_buf : front_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      gap_cnt         <= 4'd0;
      swap_pending    <= 1'b0;
      up_enable       <= 1'b0;
      up_base_address <= 32'd0;
      up_total_size   <= 32'd0;
      up_word_mode    <= 1'b0;
      up_transform    <= 1'b0;
      fifo_flush      <= 1'b0;
      front_buf       <= 1'b0;
      swap_done       <= 1'b0;
      err_irq         <= 1'b0;
      err_count       <= 8'd0;
      frame_cnt       <= 16'd0;
    end else begin
      fifo_flush <= 1'b0;
      swap_done  <= 1'b0;
      err_irq    <= 1'b0;

      // A request arriving on the restart edge survives for the next restart.
      if (host_swap_req) begin
        swap_pending <= 1'b1;
      end else if (restart_entry) begin
        swap_pending <= 1'b0;
      end

      if (!cfg_run) begin
        state     <= ST_IDLE;
        up_enable <= 1'b0;
      end else if (restart_entry) begin
        state           <= ST_RESTART;
        up_enable       <= 1'b0;
        front_buf       <= new_front;
        swap_done       <= swap_pending;
        up_base_address <= new_front ? cfg_buf1_addr : cfg_buf0_addr;
        up_total_size   <= cfg_frame_size;
        up_word_mode    <= cfg_word_mode;
        up_transform    <= cfg_transform;
        fifo_flush      <= 1'b1;
        gap_cnt         <= GAP_LOAD;
      end else begin
        case (state)
          ST_RESTART: begin
            if (gap_cnt == 4'd0) begin
              state     <= ST_RUN;
              up_enable <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          ST_RUN: begin
            if (up_read_error) begin
              state     <= ST_ERROR;
              up_enable <= 1'b0;
              err_irq   <= 1'b1;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Self-checking bench for pixel_frame_scheduler: a vector table for the basic/swap
// sequences, hand-written corner cases, then random traffic against a timing-level model.
module tb_pixel_frame_scheduler;

  localparam int GAP_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_run;
  logic [31:0] cfg_buf0_addr;
  logic [31:0] cfg_buf1_addr;
  logic [31:0] cfg_frame_size;
  logic        cfg_word_mode;
  logic        cfg_transform;
  logic        frame_start;
  logic        host_swap_req;
  logic        up_read_error;
  logic        up_enable;
  logic [31:0] up_base_address;
  logic [31:0] up_total_size;
  logic        up_word_mode;
  logic        up_transform;
  logic        fifo_flush;
  logic        front_buf;
  logic        swap_done;
  logic        err_irq;
  logic [7:0]  err_count;
  logic [15:0] frame_cnt;

  int assertCount = 0;
  int failCount   = 0;

  pixel_frame_scheduler #(.GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_run(cfg_run),
    .cfg_buf0_addr(cfg_buf0_addr), .cfg_buf1_addr(cfg_buf1_addr),
    .cfg_frame_size(cfg_frame_size), .cfg_word_mode(cfg_word_mode),
    .cfg_transform(cfg_transform), .frame_start(frame_start),
    .host_swap_req(host_swap_req), .up_read_error(up_read_error),
    .up_enable(up_enable), .up_base_address(up_base_address),
    .up_total_size(up_total_size), .up_word_mode(up_word_mode),
    .up_transform(up_transform), .fifo_flush(fifo_flush),
    .front_buf(front_buf), .swap_done(swap_done), .err_irq(err_irq),
    .err_count(err_count), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          run, fs, sw, er;
    bit          en, fl, sd, fr;
    logic [31:0] base;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  // Timing-level reference: tracks whether the uploader is enabled and how many
  // gap cycles remain before it will be, rather than any state machine.
  bit          m_en, m_flush, m_sdone, m_irq, m_front, m_pending, m_wm, m_tr;
  int          m_gap_left, m_errs;
  logic [15:0] m_frames;
  logic [31:0] m_base, m_size;

  function automatic vec_t mk(int run, int fs, int sw, int er, int en, int fl, int sd,
                              int fr, int base, int cnt);
    vec_t r;
    r.run = (run != 0); r.fs = (fs != 0); r.sw = (sw != 0); r.er = (er != 0);
    r.en = (en != 0); r.fl = (fl != 0); r.sd = (sd != 0); r.fr = (fr != 0);
    r.base = 32'(base); r.cnt = 16'(cnt);
    return r;
  endfunction

  function automatic logic [127:0] outVec();
    return {33'd0, up_enable, fifo_flush, swap_done, err_irq, front_buf, up_word_mode,
            up_transform, err_count, frame_cnt, up_base_address, up_total_size};
  endfunction

  function automatic logic [127:0] modelVec();
    return {33'd0, m_en, m_flush, m_sdone, m_irq, m_front, m_wm, m_tr, 8'(m_errs),
            m_frames, m_base, m_size};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int run, input int fs, input int sw, input int er);
    cfg_run       = (run != 0);
    frame_start   = (fs != 0);
    host_swap_req = (sw != 0);
    up_read_error = (er != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic runGap(input string name, input int cnt);
    for (int k = 1; k < GAP_CYCLES; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput({name, "_gap_en"}, 128'(up_enable), 128'(0));
    end
    applyStimulus(1, 0, 0, 0);
    checkOutput({name, "_rise"}, 128'({up_enable, frame_cnt}), 128'({1'b1, 16'(cnt)}));
  endtask

  task automatic modelStep();
    m_flush = 1'b0; m_sdone = 1'b0; m_irq = 1'b0;
    if (!cfg_run) begin
      m_en = 1'b0;
      m_gap_left = 0;
    end else if (m_en && up_read_error) begin
      m_en = 1'b0;
      m_irq = 1'b1;
      if (m_errs < 255) m_errs++;
    end else if (frame_start) begin
      if (m_pending) begin
        m_front = !m_front;
        m_sdone = 1'b1;
        m_pending = 1'b0;
      end
      m_base = m_front ? cfg_buf1_addr : cfg_buf0_addr;
      m_size = cfg_frame_size;
      m_wm = cfg_word_mode;
      m_tr = cfg_transform;
      m_flush = 1'b1;
      m_en = 1'b0;
      m_gap_left = GAP_CYCLES;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
      if (m_gap_left == 0) begin
        m_en = 1'b1;
        m_frames = m_frames + 16'd1;
      end
    end
    if (host_swap_req) m_pending = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    cfg_run = 1'b0; frame_start = 1'b0; host_swap_req = 1'b0; up_read_error = 1'b0;
    cfg_buf0_addr = 32'h1000; cfg_buf1_addr = 32'h2000; cfg_frame_size = 32'h300;
    cfg_word_mode = 1'b1; cfg_transform = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", outVec(), 128'(0));
    rst_n = 1'b1;

    // Basic start, swap, unchanged buffer on plain restart, same-cycle swap request.
    tbl.push_back(mk(1,1,0,0, 0,1,0,0, 'h1000, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 0,0,0,0, 'h1000, 0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0, 'h1000, 1));
    tbl.push_back(mk(1,0,1,0, 1,0,0,0, 'h1000, 1));
    tbl.push_back(mk(1,1,0,0, 0,1,1,1, 'h2000, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 0,0,0,1, 'h2000, 1));
    tbl.push_back(mk(1,0,0,0, 1,0,0,1, 'h2000, 2));
    tbl.push_back(mk(1,1,0,0, 0,1,0,1, 'h2000, 2));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 0,0,0,1, 'h2000, 2));
    tbl.push_back(mk(1,0,0,0, 1,0,0,1, 'h2000, 3));
    tbl.push_back(mk(1,1,1,0, 0,1,0,1, 'h2000, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 0,0,0,1, 'h2000, 3));
    tbl.push_back(mk(1,0,0,0, 1,0,0,1, 'h2000, 4));
    tbl.push_back(mk(1,1,0,0, 0,1,1,0, 'h1000, 4));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 0,0,0,0, 'h1000, 4));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0, 'h1000, 5));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(int'(tbl[i].run), int'(tbl[i].fs), int'(tbl[i].sw), int'(tbl[i].er));
      checkOutput($sformatf("vec%0d", i),
                  128'({up_enable, fifo_flush, swap_done, front_buf, up_base_address, frame_cnt}),
                  128'({tbl[i].en, tbl[i].fl, tbl[i].sd, tbl[i].fr, tbl[i].base, tbl[i].cnt}));
    end
    checkOutput("latched_cfg", 128'({up_total_size, up_word_mode, up_transform}),
                128'({32'h300, 1'b1, 1'b0}));

    // Error together with a frame boundary: error wins, no flush.
    applyStimulus(1, 1, 0, 1);
    checkOutput("err_entry", 128'({up_enable, err_irq, fifo_flush, err_count}),
                128'({1'b0, 1'b1, 1'b0, 8'd1}));
    applyStimulus(1, 0, 0, 1);
    checkOutput("err_ignored", 128'({up_enable, err_irq, err_count}), 128'({1'b0, 1'b0, 8'd1}));
    applyStimulus(1, 1, 0, 0);
    checkOutput("err_retry_flush", 128'({up_enable, fifo_flush}), 128'({1'b0, 1'b1}));
    runGap("err_retry", 6);

    // Second frame_start on the 2nd restart cycle reloads the gap.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("mid_restart", 128'({up_enable, fifo_flush, frame_cnt}),
                128'({1'b0, 1'b1, 16'd6}));
    runGap("mid_restart", 7);

    // Stop during restart: no flush, enable never rises.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("stop", 128'({up_enable, fifo_flush}), 128'(0));
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, (k == 2) ? 1 : 0, 0, 0);
      checkOutput($sformatf("stopped%0d", k), 128'({up_enable, fifo_flush, frame_cnt}),
                  128'({1'b0, 1'b0, 16'd7}));
    end

    applyStimulus(1, 1, 0, 0);
    runGap("resume", 8);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 1, 0, 0);
      for (int g = 0; g < GAP_CYCLES; g++) applyStimulus(1, 0, 0, 0);
    end
    checkOutput("err_saturate", 128'(err_count), 128'(8'd255));

    // Asynchronous reset while running, between clock edges.
    checkOutput("pre_reset_en", 128'(up_enable), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", outVec(), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    m_en = 0; m_flush = 0; m_sdone = 0; m_irq = 0; m_front = 0; m_pending = 0;
    m_wm = 0; m_tr = 0; m_gap_left = 0; m_errs = 0; m_frames = 16'd0;
    m_base = 32'd0; m_size = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        cfg_buf0_addr  = $urandom;
        cfg_buf1_addr  = $urandom;
        cfg_frame_size = $urandom;
      end
      cfg_word_mode = 1'($urandom_range(0, 1));
      cfg_transform = 1'($urandom_range(0, 1));
      cfg_run       = ($urandom_range(0, 39) != 0);
      frame_start   = ($urandom_range(0, 7) == 0);
      host_swap_req = ($urandom_range(0, 9) == 0);
      up_read_error = ($urandom_range(0, 11) == 0);
      modelStep();
      applyStimulus(int'(cfg_run), int'(frame_start), int'(host_swap_req), int'(up_read_error));
      checkOutput($sformatf("rand%0d", c), outVec(), modelVec());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
